// File: rtl/fp16mul_drain_pkg.sv
// Shared constants, read-FSM encoding and fp32 class helpers for the drain stage.
package fp16mul_drain_pkg;

    localparam int unsigned LANES            = 32;
    localparam int unsigned BEAT_LANES       = 4;
    localparam int unsigned DEPTH            = 2;
    localparam int unsigned FP32_W           = 32;
    localparam logic [7:0]  FP32_EXP_ALLONES = 8'hFF;
    localparam int unsigned BEATS            = LANES / BEAT_LANES;

    localparam int unsigned SLICE_W = LANES * 4;            // one bit-sliced input register
    localparam int unsigned BLOCK_W = LANES * FP32_W;       // one de-interleaved block
    localparam int unsigned BEAT_W  = BEAT_LANES * FP32_W;  // one output beat
    localparam int unsigned BEAT_CW = $clog2(BEATS);
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

    typedef enum logic {
        StIdle,
        StStream
    } rd_state_e;

    function automatic logic fp32_is_nan(input logic [FP32_W-1:0] w);
        return (w[30:23] == FP32_EXP_ALLONES) && (w[22:0] != 23'd0);
    endfunction

    function automatic logic fp32_is_inf(input logic [FP32_W-1:0] w);
        return (w[30:23] == FP32_EXP_ALLONES) && (w[22:0] == 23'd0);
    endfunction

endpackage

// File: rtl/fp16mul_drain_unpack.sv
// Combinational de-interleave of eight nibble-sliced registers into packed fp32 lanes.
// Slice n carries nibble n of every lane: d_n[4k+3:4k] = lane k bits [4n+3:4n].
module fp32_slice_unpack
    import fp16mul_drain_pkg::*;
(
    input  logic [SLICE_W-1:0] i_d0,
    input  logic [SLICE_W-1:0] i_d1,
    input  logic [SLICE_W-1:0] i_d2,
    input  logic [SLICE_W-1:0] i_d3,
    input  logic [SLICE_W-1:0] i_d4,
    input  logic [SLICE_W-1:0] i_d5,
    input  logic [SLICE_W-1:0] i_d6,
    input  logic [SLICE_W-1:0] i_d7,
    output logic [BLOCK_W-1:0] o_words
);

    logic [SLICE_W-1:0] w_d [8];

    assign w_d[0] = i_d0;
    assign w_d[1] = i_d1;
    assign w_d[2] = i_d2;
    assign w_d[3] = i_d3;
    assign w_d[4] = i_d4;
    assign w_d[5] = i_d5;
    assign w_d[6] = i_d6;
    assign w_d[7] = i_d7;

    // Gather nibble n of lane k from slice n into lane k's packed word.
    always_comb begin
        o_words = '0;
        for (int k = 0; k < LANES; k++) begin
            for (int n = 0; n < 8; n++) begin
                o_words[k*FP32_W + 4*n +: 4] = w_d[n][4*k +: 4];
            end
        end
    end

endmodule

// File: rtl/fp16mul_drain.sv
// Drain stage: captures bit-sliced multiplier results into a ping-pong buffer and
// streams each block out as eight 128-bit beats over a valid/ready bus.
module fp16mul_drain
    import fp16mul_drain_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [SLICE_W-1:0]    i_d0,
    input  logic [SLICE_W-1:0]    i_d1,
    input  logic [SLICE_W-1:0]    i_d2,
    input  logic [SLICE_W-1:0]    i_d3,
    input  logic [SLICE_W-1:0]    i_d4,
    input  logic [SLICE_W-1:0]    i_d5,
    input  logic [SLICE_W-1:0]    i_d6,
    input  logic [SLICE_W-1:0]    i_d7,
    input  logic                  i_cap_valid,
    output logic                  o_cap_ready,
    input  logic                  i_flush,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [BEAT_W-1:0]     o_out_data,
    output logic [BEAT_CW-1:0]    o_out_beat,
    output logic                  o_out_last,
    output logic [BEAT_LANES-1:0] o_out_nan,
    output logic [BEAT_LANES-1:0] o_out_inf,
    output logic                  o_overflow
);

    localparam logic [BEAT_CW-1:0] LAST_BEAT = BEAT_CW'(BEATS - 1);
    localparam logic [CNT_W-1:0]   FULL_CNT  = CNT_W'(DEPTH);

    rd_state_e          r_state;
    rd_state_e          w_state_d;
    logic [BEAT_CW-1:0] r_beat;
    logic [BEAT_CW-1:0] w_beat_d;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_d;
    logic               r_wr_ptr;   // DEPTH==2: a single toggling bit selects the slot
    logic               r_rd_ptr;
    logic               r_overflow;
    logic [BLOCK_W-1:0] r_buf [DEPTH];

    logic [BLOCK_W-1:0] w_unpacked;
    logic [BLOCK_W-1:0] w_slot;
    logic               w_cap;
    logic               w_pop;

    fp32_slice_unpack u_unpack (
        .i_d0    (i_d0),
        .i_d1    (i_d1),
        .i_d2    (i_d2),
        .i_d3    (i_d3),
        .i_d4    (i_d4),
        .i_d5    (i_d5),
        .i_d6    (i_d6),
        .i_d7    (i_d7),
        .o_words (w_unpacked)
    );

    // cap_ready reflects the registered count only; a same-cycle pop does not free a slot.
    assign o_cap_ready = (r_count < FULL_CNT);
    assign o_out_valid = (r_state == StStream);
    assign o_out_beat  = r_beat;
    assign o_out_last  = o_out_valid && (r_beat == LAST_BEAT);
    assign o_overflow  = r_overflow;

    assign w_cap  = i_cap_valid && o_cap_ready;
    assign w_pop  = o_out_valid && i_out_ready && (r_beat == LAST_BEAT);
    assign w_slot = r_buf[r_rd_ptr];

    // Beat select and per-word class flags from the slot being read.
    always_comb begin
        o_out_data = w_slot[int'(r_beat)*BEAT_W +: BEAT_W];
        o_out_nan  = '0;
        o_out_inf  = '0;
        for (int i = 0; i < BEAT_LANES; i++) begin
            o_out_nan[i] = fp32_is_nan(o_out_data[i*FP32_W +: FP32_W]);
            o_out_inf[i] = fp32_is_inf(o_out_data[i*FP32_W +: FP32_W]);
        end
    end

    // Occupancy and read-FSM next state; Idle also wakes on a same-cycle capture.
    always_comb begin
        w_count_d = r_count;
        w_state_d = r_state;
        w_beat_d  = r_beat;

        unique case ({w_cap, w_pop})
            2'b10:   w_count_d = r_count + CNT_W'(1);
            2'b01:   w_count_d = r_count - CNT_W'(1);
            default: w_count_d = r_count;
        endcase

        unique case (r_state)
            StIdle: begin
                w_beat_d = '0;
                if ((r_count != '0) || w_cap) begin
                    w_state_d = StStream;
                end
            end
            StStream: begin
                if (i_out_ready) begin
                    if (r_beat == LAST_BEAT) begin
                        w_beat_d = '0;
                        // Another block is (or is becoming) resident: continue without a bubble.
                        if ((r_count == FULL_CNT) || w_cap) begin
                            w_state_d = StStream;
                        end else begin
                            w_state_d = StIdle;
                        end
                    end else begin
                        w_beat_d = r_beat + BEAT_CW'(1);
                    end
                end
            end
            default: begin
                w_state_d = StIdle;
                w_beat_d  = '0;
            end
        endcase
    end

    // State, pointers, buffer and sticky overflow; flush leaves buffer contents stale.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_beat     <= '0;
            r_count    <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else if (i_flush) begin
            r_state    <= StIdle;
            r_beat     <= '0;
            r_count    <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_beat  <= w_beat_d;
            r_count <= w_count_d;
            if (w_cap) begin
                r_buf[r_wr_ptr] <= w_unpacked;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            if (i_cap_valid && !o_cap_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: doc/fp16mul_drain.md
Name: fp16mul_drain

Overview:
- Downstream stage of the 32-lane fp16 multiplier.
- Captures the eight 128-bit bit-sliced result registers (d0..d7) on a strobe and de-interleaves them into 32 packed fp32 words.
- Streams the words out four per beat over a 128-bit valid/ready bus to the writeback/DVR path.
- A two-slot ping-pong buffer decouples multiplier issue from downstream backpressure.

Parameters:
- LANES, 32, fp32 results per capture (must match multiplier lane count).
- BEAT_LANES, 4, fp32 words per output beat; beats per block = LANES/BEAT_LANES = 8.
- DEPTH, 2, number of buffered capture blocks (ping-pong).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- d0..d7  in  128 each  multiplier result slices; d_n[4k+3:4k] = fp32 lane k bits [4n+3:4n].
- cap_valid  in  1  capture strobe; pulse one cycle after the multiplier result registers update.
- cap_ready  out  1  buffer has a free slot (count < DEPTH).
- flush  in  1  synchronous clear of buffer, stream state and overflow flag.
- out_valid  out  1  beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  128  lanes 4b..4b+3; lane 4b in [31:0], lane 4b+3 in [127:96].
- out_beat  out  3  beat index b within the block, 0..7.
- out_last  out  1  high on beat 7.
- out_nan  out  4  per-word NaN flag: exp==8'hFF and mant!=0.
- out_inf  out  4  per-word Inf flag: exp==8'hFF and mant==0.
- overflow  out  1  sticky; a capture was dropped because the buffer was full.

Behaviour:
- Reset (rst=1 at posedge), all state cleared:
  - out_valid=0, out_beat=0, out_last=0, out_data=0, out_nan=0, out_inf=0, overflow=0.
  - cap_ready=1, count=0, wr_ptr=rd_ptr=0, buffer contents 0.
  - Reset mid-stream abandons the block; no further beats are emitted.
- Capture:
  - cap_valid && cap_ready at edge T: de-interleaved block written to slot wr_ptr, wr_ptr toggles, count increments.
  - cap_valid && !cap_ready: block dropped, overflow set at T+1 and held until rst or flush.
- Read FSM:
  - IDLE: out_valid=0. When count>0, go to STREAM at the next edge with beat=0.
  - First beat is visible at T+1 after a capture into an empty buffer: single-cycle latency, no combinational path from cap_valid to out_valid.
  - STREAM: out_valid=1. Beat advances only on out_valid && out_ready; out_valid, out_data and out_beat hold stable while stalled.
  - On an accepted beat 7: rd_ptr toggles and count decrements.
  - If count was 2, or a capture occurs in the same cycle, stay in STREAM at beat 0 of the next slot (no bubble). Otherwise go to IDLE.
- Simultaneous capture and last-beat pop:
  - count unchanged.
  - With count==2, cap_ready is still 0 that cycle, so the capture is dropped and overflow set. cap_ready does not look ahead.
- out_data, out_nan and out_inf are combinational from slot rd_ptr and the beat counter. Flags are decoded on each 32-bit word.
- flush:
  - Highest priority after rst.
  - Same clearing as reset except buffer contents may be left stale.
  - A cap_valid in the flush cycle is ignored.
- No data is modified: bit-exact re-packing only.

Decomposition:
- Shared package holds:
  - localparams FP32_W=32, FP32_EXP_ALLONES=8'hFF, BEATS=LANES/BEAT_LANES.
  - The read FSM state encoding (IDLE, STREAM).
- One sub-module, fp32_slice_unpack: purely combinational, 8x128 bit-sliced input to 32x32 packed words. Instantiated once on the capture path.
- The FSM, pointers and buffer stay in the top module.

Test Plan:
- Capture block where every lane = 1.0 (d5=128'h8888…8, d6=128'hFFFF…F, d7=128'h3333…3, others 0), out_ready=1 → out_valid at T+1, 8 consecutive beats of 128'h3F800000_3F800000_3F800000_3F800000, out_last on beat 7, then out_valid=0.
- Lane k word = 32'h0000_0000 + k (set nibble slices accordingly), out_ready held 0 for 5 cycles then 1 → beat 0 = {32'd3,32'd2,32'd1,32'd0} held stable while stalled; beat 7 = {32'd31,32'd30,32'd29,32'd28}.
- Two captures back-to-back, out_ready=0 → cap_ready=0 after second; third cap_valid → overflow=1. Release ready → 16 beats with no gap between blocks, block A before block B.
- Lanes 0..3 = 7FC00000, FF800000, 7F800000, 3F800000 → beat 0 out_nan=4'b0001, out_inf=4'b0110.
- Assert rst, then separately flush, at beat 3 of a stream with one block queued → next cycle out_valid=0, cap_ready=1, overflow=0; a new capture streams from beat 0.
